ibex_zkn_aes_seq: RTL and testbench

Multi-cycle sequencer for the Zkn AES32 instructions (aes32esi/esmi/dsi/dsmi) in the EX stage. It captures the operands, wins access to a shared byte S-box (forward/inverse), applies the MixColumn byte expansion and rotation, and XORs the result into rs1. It presents the result to ID with the same valid/ready discipline the multiplier/divider uses. The S-box is an external shared resource behind a req/gnt handshake, so the sequencer tolerates arbitrary grant delay.

---
 rtl/ibex_zkn_aes_seq.sv | 146 ++++++++++++++
 tb/tb_ibex_zkn_aes_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_zkn_aes_seq.sv
// ibex_zkn_aes_seq: multi-cycle sequencer for the AES32 (esi/esmi/dsi/dsmi)
// instructions. It captures operands, requests the shared byte S-box, waits
// for its fixed-latency response, applies the optional MixColumn expansion and
// rotation, XORs into rs1 and holds the result until ID accepts it.
module ibex_zkn_aes_seq #(
   parameter int unsigned SBoxLatency = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [1:0]  bs_i,
   input  logic        mr_i,
   input  logic        enc_dec_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        ready_id_i,
   output logic        sbox_req_o,
   input  logic        sbox_gnt_i,
   output logic        sbox_inv_o,
   output logic [7:0]  sbox_in_o,
   input  logic [7:0]  sbox_out_i,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e      r_state, w_state_nxt;
   logic [1:0]  r_bs;
   logic        r_mr;
   logic        r_enc;
   logic [31:0] r_opa;
   logic [7:0]  r_b;
   logic [1:0]  r_cnt;
   logic [31:0] r_result;

   logic        w_load;
   logic        w_gnt;
   logic        w_cap;
   logic [7:0]  w_sel_b;
   logic [31:0] w_mixed;
   logic [31:0] w_result;

   // GF(2^8) doubling, polynomial 0x11B
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   assign w_load = (r_state == S_IDLE) && en_i;
   assign w_gnt  = (r_state == S_REQ) && sbox_gnt_i;
   assign w_cap  = (r_state == S_WAIT) && (r_cnt == 2'd1);

   // pick the rs2 byte addressed by bs
   always_comb begin
      w_sel_b = op_b_i[7:0];
      case (bs_i)
         2'd0: w_sel_b = op_b_i[7:0];
         2'd1: w_sel_b = op_b_i[15:8];
         2'd2: w_sel_b = op_b_i[23:16];
         2'd3: w_sel_b = op_b_i[31:24];
         default: w_sel_b = op_b_i[7:0];
      endcase
   end

   // MixColumn byte expansion, rotation into place and XOR into rs1
   always_comb begin
      logic [7:0] s, s2, s4, s8;
      s  = sbox_out_i;
      s2 = xt(s);
      s4 = xt(s2);
      s8 = xt(s4);
      w_mixed = {24'h0, s};
      if (r_mr) begin
         if (r_enc) w_mixed = {s2 ^ s, s, s, s2};
         else       w_mixed = {s8 ^ s2 ^ s, s8 ^ s4 ^ s, s8 ^ s, s8 ^ s4 ^ s2};
      end
      w_result = r_opa;
      case (r_bs)
         2'd0: w_result = r_opa ^ w_mixed;
         2'd1: w_result = r_opa ^ {w_mixed[23:0], w_mixed[31:24]};
         2'd2: w_result = r_opa ^ {w_mixed[15:0], w_mixed[31:16]};
         2'd3: w_result = r_opa ^ {w_mixed[7:0],  w_mixed[31:8]};
         default: w_result = r_opa;
      endcase
   end

   // next-state decode; a granted access always drains through WAIT
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (en_i) w_state_nxt = S_REQ;
         S_REQ: begin
            if (sbox_gnt_i)  w_state_nxt = S_WAIT;
            else if (!en_i)  w_state_nxt = S_IDLE;
         end
         S_WAIT: if (r_cnt == 2'd1) w_state_nxt = en_i ? S_DONE : S_IDLE;
         S_DONE: if (ready_id_i || !en_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // operand capture when an op starts from IDLE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bs  <= '0;
         r_mr  <= 1'b0;
         r_enc <= 1'b0;
         r_opa <= '0;
         r_b   <= '0;
      end else if (w_load) begin
         r_bs  <= bs_i;
         r_mr  <= mr_i;
         r_enc <= enc_dec_i;
         r_opa <= op_a_i;
         r_b   <= w_sel_b;
      end
   end

   // S-box latency counter: loaded on grant, counts down while waiting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   r_cnt <= '0;
      else if (w_gnt)                r_cnt <= 2'(SBoxLatency);
      else if (r_state == S_WAIT)    r_cnt <= r_cnt - 2'd1;
   end

   // result register, written the cycle the S-box data is valid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    r_result <= '0;
      else if (w_cap) r_result <= w_result;
   end

   assign sbox_req_o = (r_state == S_REQ);
   assign sbox_in_o  = (r_state == S_REQ) ? r_b : 8'h00;
   assign sbox_inv_o = (r_state == S_REQ) ? ~r_enc : 1'b0;
   assign valid_o    = (r_state == S_DONE);
   assign result_o   = (r_state == S_DONE) ? r_result : 32'h0;
   assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ibex_zkn_aes_seq.sv
// Directed bench for ibex_zkn_aes_seq: two instances (S-box latency 1 and 2)
// each served by a behavioural S-box with programmable grant delay. Expected
// results are pushed to per-instance queues at issue and popped on valid_o.
module tb_ibex_zkn_aes_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en1 = 1'b0, en2 = 1'b0;
   logic [1:0]  bs = '0;
   logic        mr = 1'b0, enc = 1'b0, rdy = 1'b1;
   logic [31:0] opa = '0, opb = '0;

   logic        req1, gnt1, inv1, valid1, busy1;
   logic [7:0]  sin1, sout1;
   logic [31:0] res1;
   logic        req2, gnt2, inv2, valid2, busy2;
   logic [7:0]  sin2, sout2;
   logic [31:0] res2;

   int          gd1 = 0, gd2 = 0;
   int          rc1, rc2;
   logic [7:0]  p1, p2a, p2b;

   logic [31:0] q1[$];
   logic [31:0] q2[$];
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   ibex_zkn_aes_seq #(.SBoxLatency(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .bs_i(bs), .mr_i(mr),
      .enc_dec_i(enc), .op_a_i(opa), .op_b_i(opb), .ready_id_i(rdy),
      .sbox_req_o(req1), .sbox_gnt_i(gnt1), .sbox_inv_o(inv1),
      .sbox_in_o(sin1), .sbox_out_i(sout1), .valid_o(valid1),
      .result_o(res1), .busy_o(busy1));

   ibex_zkn_aes_seq #(.SBoxLatency(2)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .bs_i(bs), .mr_i(mr),
      .enc_dec_i(enc), .op_a_i(opa), .op_b_i(opb), .ready_id_i(rdy),
      .sbox_req_o(req2), .sbox_gnt_i(gnt2), .sbox_inv_o(inv2),
      .sbox_in_o(sin2), .sbox_out_i(sout2), .valid_o(valid2),
      .result_o(res2), .busy_o(busy2));

   // behavioural S-box: 0x53 <-> 0xED as in AES, anything else arbitrary
   function automatic logic [7:0] sbf(input logic [7:0] x, input logic inv);
      if (!inv) return (x == 8'h53) ? 8'hED : ({x[3:0], x[7:4]} ^ 8'h63);
      else      return (x == 8'hED) ? 8'h53 : (x ^ 8'hA5);
   endfunction

   // shift-and-add GF(2^8) multiply, polynomial 0x11B
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [31:0] model(input logic [1:0] b_s, input logic m,
                                         input logic e, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [7:0]  byt, s;
      logic [31:0] mx;
      logic [63:0] dbl;
      byt = b[8*b_s +: 8];
      s   = sbf(byt, !e);
      if (!m)     mx = {24'h0, s};
      else if (e) mx = {gm(s, 8'h03), s, s, gm(s, 8'h02)};
      else        mx = {gm(s, 8'h0B), gm(s, 8'h0D), gm(s, 8'h09), gm(s, 8'h0E)};
      dbl = {mx, mx} << (8 * b_s);
      return a ^ dbl[63:32];
   endfunction

   // grant after gdN cycles of request; data appears SBoxLatency later
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc1 <= 0; rc2 <= 0; p1 <= '0; p2a <= '0; p2b <= '0;
      end else begin
         rc1 <= (req1 && !gnt1) ? rc1 + 1 : 0;
         rc2 <= (req2 && !gnt2) ? rc2 + 1 : 0;
         p1  <= (req1 && gnt1) ? sbf(sin1, inv1) : 8'h00;
         p2a <= (req2 && gnt2) ? sbf(sin2, inv2) : 8'h00;
         p2b <= p2a;
      end
   end
   assign gnt1  = req1 && (rc1 >= gd1);
   assign gnt2  = req2 && (rc2 >= gd2);
   assign sout1 = p1;
   assign sout2 = p2b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int d, input logic [1:0] b_s, input logic m,
                           input logic e, input logic [31:0] a,
                           input logic [31:0] b, input bit push);
      bs = b_s; mr = m; enc = e; opa = a; opb = b;
      if (d == 1) begin en1 = 1'b1; if (push) q1.push_back(model(b_s, m, e, a, b)); end
      else        begin en2 = 1'b1; if (push) q2.push_back(model(b_s, m, e, a, b)); end
   endtask

   // bounded wait for valid_o, then pop the scoreboard and compare
   task automatic wait_valid(input int d, output int cyc);
      logic        v;
      logic [31:0] r, e;
      cyc = 0; v = 1'b0;
      while (!v && cyc < 20) begin
         tick();
         cyc++;
         v = (d == 1) ? valid1 : valid2;
      end
      chk("valid_seen", {31'h0, v}, 32'd1);
      r = (d == 1) ? res1 : res2;
      e = 'x;
      if (d == 1 && q1.size() > 0) e = q1.pop_front();
      if (d == 2 && q2.size() > 0) e = q2.pop_front();
      chk("result", r, e);
   endtask

   initial begin
      int          cyc;
      logic [31:0] e_bp;

      // reset values
      tick(); tick();
      chk("rst_out1", {req1, inv1, sin1, valid1, busy1}, '0);
      chk("rst_res1", res1, 32'h0);
      chk("rst_out2", {req2, inv2, sin2, valid2, busy2}, '0);
      chk("rst_res2", res2, 32'h0);
      rst_n = 1'b1;
      tick();

      // aes32esi, immediate grant
      start_op(1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h00000053, 1'b1);
      tick();
      chk("esi_req", {req1, inv1, sin1}, {1'b1, 1'b0, 8'h53});
      wait_valid(1, cyc);
      chk("esi_lat", 1 + cyc, 3);
      chk("esi_res", res1, 32'h000000ED);
      en1 = 1'b0;
      tick();
      chk("esi_idle", {valid1, busy1, res1}, '0);

      // aes32esmi
      start_op(1, 2'd0, 1'b1, 1'b1, 32'h0, 32'h00000053, 1'b1);
      tick();
      wait_valid(1, cyc);
      chk("esmi_res", res1, 32'h2CEDEDC1);
      en1 = 1'b0;
      tick();

      // aes32esi with rotation
      start_op(1, 2'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00005300, 1'b1);
      tick();
      chk("rot_in", {24'h0, sin1}, 32'h53);
      wait_valid(1, cyc);
      chk("rot_res", res1, 32'hFFFF12FF);
      en1 = 1'b0;
      tick();

      // aes32dsi, grant withheld 3 cycles, S-box latency 2
      gd2 = 3;
      start_op(2, 2'd3, 1'b0, 1'b0, 32'h0, 32'hED000000, 1'b1);
      tick();
      chk("dsi_req_c1", {req2, inv2, sin2}, {1'b1, 1'b1, 8'hED});
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("dsi_req_hold", {req2, inv2, sin2}, {1'b1, 1'b1, 8'hED});
      end
      wait_valid(2, cyc);
      chk("dsi_lat", 4 + cyc, 7);
      chk("dsi_res", res2, 32'h53000000);
      en2 = 1'b0;
      gd2 = 0;
      tick();

      // aes32dsmi with nonzero rs1 on the latency-2 instance
      start_op(2, 2'd2, 1'b1, 1'b0, 32'h12345678, 32'h00C40000, 1'b1);
      tick();
      wait_valid(2, cyc);
      chk("dsmi_lat", 1 + cyc, 4);
      en2 = 1'b0;
      tick();

      // backpressure in DONE, then back-to-back reissue
      rdy = 1'b0;
      e_bp = model(2'd2, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h00C30000);
      start_op(1, 2'd2, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h00C30000, 1'b1);
      tick();
      wait_valid(1, cyc);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", {31'h0, valid1}, 32'd1);
         chk("bp_res", res1, e_bp);
      end
      start_op(1, 2'd0, 1'b0, 1'b1, 32'h0F0F0F0F, 32'h0000009A, 1'b1);
      rdy = 1'b1;
      tick();
      chk("bp_idle", {31'h0, busy1 | valid1}, 32'd0);
      tick();
      chk("reissue_req", {req1, sin1}, {1'b1, 8'h9A});
      wait_valid(1, cyc);
      chk("reissue_lat", 1 + cyc, 3);
      en1 = 1'b0;
      tick();

      // abort in REQ
      gd1 = 5;
      start_op(1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h00000011, 1'b0);
      tick();
      chk("abort_req", {31'h0, req1}, 32'd1);
      tick();
      en1 = 1'b0;
      tick();
      chk("abort_idle", {req1, busy1, valid1}, 3'b000);
      tick();
      chk("abort_novalid", {31'h0, valid1}, 32'd0);
      gd1 = 0;

      // reset pulse while waiting on the S-box
      start_op(2, 2'd1, 1'b1, 1'b1, 32'h0, 32'h00002200, 1'b0);
      tick();
      tick();
      chk("wait_busy", {31'h0, busy2}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_out", {req2, inv2, sin2, valid2, busy2}, '0);
      chk("rst_mid_res", res2, 32'h0);
      en2 = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      start_op(2, 2'd1, 1'b1, 1'b1, 32'hCAFEF00D, 32'h00002200, 1'b1);
      tick();
      wait_valid(2, cyc);
      chk("post_rst_lat", 1 + cyc, 4);
      en2 = 1'b0;
      tick();
      chk("sb_empty", q1.size() + q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
